// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - parametrised SCCB/I2C master, 3-phase write and 2-phase read
// Drives open-drain enables only; the pad buffers live in the top level.
module sccb_master #(
   parameter int         CLK_DIV        = 250,
   parameter logic [7:0] DEV_ADDR       = 8'h42,
   parameter int         REG_ADDR_BYTES = 1,
   parameter bit         ACK_CHECK      = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start_i,
   input  logic                        rw_i,
   input  logic [8*REG_ADDR_BYTES-1:0] reg_addr_i,
   input  logic [7:0]                  wdata_i,
   output logic                        ready_o,
   output logic                        done_o,
   output logic                        nack_o,
   output logic [7:0]                  rdata_o,
   output logic                        scl_oe_o,
   output logic                        sda_oe_o,
   input  logic                        sda_i
);
   localparam int            QW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QLAST     = QW'(CLK_DIV - 1);
   localparam logic [2:0]    ADDR_LAST = 3'(REG_ADDR_BYTES);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE} state_t;

   state_t                      state;
   logic [QW-1:0]               qcnt;
   logic [1:0]                  qtr;
   logic [3:0]                  bit_cnt;
   logic [2:0]                  byte_idx;
   logic                        phase2;
   logic                        rw;
   logic [8*REG_ADDR_BYTES-1:0] reg_addr;
   logic [7:0]                  wdata;
   logic [7:0]                  tx_byte;
   logic [7:0]                  rx_shift;

   logic       busy;
   logic       qtick;
   logic       rx_byte;
   logic [2:0] last_idx;

   assign busy     = (state != S_IDLE) && (state != S_DONE);
   assign qtick    = busy && (qcnt == QLAST);
   assign rx_byte  = phase2 && (byte_idx == 3'd1);
   assign last_idx = phase2 ? 3'd1 : (rw ? ADDR_LAST : ADDR_LAST + 3'd1);

   // The received byte is "sent" as all ones so SDA stays released for every bit.
   function automatic logic [7:0] byte_at(input logic [2:0] idx);
      if (phase2)
         return 8'hFF;
      if (idx > ADDR_LAST)
         return wdata;
      if (REG_ADDR_BYTES == 2 && idx == 3'd1)
         return reg_addr[8*REG_ADDR_BYTES-1 -: 8];
      return reg_addr[7:0];
   endfunction

   // Each qtick ends the current quarter; the OEs assigned there belong to the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         qcnt     <= '0;
         qtr      <= '0;
         bit_cnt  <= '0;
         byte_idx <= '0;
         phase2   <= 1'b0;
         rw       <= 1'b0;
         reg_addr <= '0;
         wdata    <= '0;
         tx_byte  <= '0;
         rx_shift <= '0;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
         nack_o   <= 1'b0;
         rdata_o  <= '0;
         scl_oe_o <= 1'b0;
         sda_oe_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         qcnt   <= (qtick || !busy) ? '0 : qcnt + QW'(1);
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  rw       <= rw_i;
                  reg_addr <= reg_addr_i;
                  wdata    <= wdata_i;
                  nack_o   <= 1'b0;
                  tx_byte  <= DEV_ADDR;
                  byte_idx <= '0;
                  bit_cnt  <= '0;
                  phase2   <= 1'b0;
                  qtr      <= '0;
                  ready_o  <= 1'b0;
                  scl_oe_o <= 1'b0;
                  sda_oe_o <= 1'b1;
                  state    <= S_START;
               end
            end
            S_DONE: state <= S_IDLE;
            default: begin
               if (qtick) begin
                  qtr <= qtr + 2'd1;
                  case (state)
                     S_START: begin
                        if (qtr == 2'd1) begin
                           qtr      <= '0;
                           bit_cnt  <= '0;
                           scl_oe_o <= 1'b1;
                           state    <= S_BIT;
                        end
                     end
                     S_BIT: begin
                        if (qtr == 2'd0) begin
                           sda_oe_o <= (bit_cnt == 4'd8) ? 1'b0 : ~tx_byte[7];
                        end else if (qtr == 2'd1) begin
                           scl_oe_o <= 1'b0;
                        end else if (qtr == 2'd3) begin
                           scl_oe_o <= 1'b1;
                           if (bit_cnt != 4'd8) begin
                              rx_shift <= {rx_shift[6:0], sda_i};
                              tx_byte  <= {tx_byte[6:0], 1'b1};
                              bit_cnt  <= bit_cnt + 4'd1;
                           end else begin
                              bit_cnt <= '0;
                              if (ACK_CHECK && sda_i && !rx_byte) begin
                                 nack_o <= 1'b1;
                                 state  <= S_STOP;
                              end else if (byte_idx == last_idx) begin
                                 state <= S_STOP;
                              end else begin
                                 byte_idx <= byte_idx + 3'd1;
                                 tx_byte  <= byte_at(byte_idx + 3'd1);
                              end
                           end
                        end
                     end
                     S_STOP: begin
                        if (qtr == 2'd0) begin
                           sda_oe_o <= 1'b1;
                        end else if (qtr == 2'd1) begin
                           scl_oe_o <= 1'b0;
                        end else if (qtr == 2'd2) begin
                           sda_oe_o <= 1'b0;
                        end else if (rw && !phase2 && !nack_o) begin
                           state <= S_GAP;
                        end else begin
                           done_o  <= 1'b1;
                           ready_o <= 1'b1;
                           if (rw && !nack_o)
                              rdata_o <= rx_shift;
                           state <= S_DONE;
                        end
                     end
                     S_GAP: begin
                        if (qtr == 2'd3) begin
                           phase2   <= 1'b1;
                           byte_idx <= '0;
                           tx_byte  <= DEV_ADDR | 8'h01;
                           sda_oe_o <= 1'b1;
                           state    <= S_START;
                        end
                     end
                     default: state <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end
endmodule

// File: doc/sccb_master.md
# sccb_master

Parametrised SCCB/I2C master for camera register configuration. It replaces the fixed write-only, delay-driven serializer: clock rate, device ID and register-address width are set at elaboration time, and it runs both 3-phase write and 2-phase read transactions. It samples the ACK bit and reports NACK. It sits between the camera init sequencer/ROM walker and the top-level open-drain IOBUFs. It drives only output-enable and sense signals, so the IOBUFs stay in the top level.

## Interface
- CLK_DIV, 250, `clk` cycles per SCL quarter-period; must be ≥ 2.
- DEV_ADDR, 8'h42, 8-bit write ID. The read ID is `DEV_ADDR | 8'h01`.
- REG_ADDR_BYTES, 1, register address bytes, 1 or 2, sent MSB first.
- ACK_CHECK, 1, 1 = abort on NACK; 0 = ignore the ACK bit (pure SCCB "don't care").
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `start_i` in 1: request. Accepted only in the cycle `ready_o`=1.
- `rw_i` in 1: 0 = write, 1 = read. Captured on accept.
- `reg_addr_i` in 8*REG_ADDR_BYTES: register address. Captured on accept.
- `wdata_i` in 8: write data. Captured on accept.
- `ready_o` out 1: idle, can accept a request.
- `done_o` out 1: one-cycle pulse at the end of a transaction.
- `nack_o` out 1: last transaction aborted on NACK. Valid from `done_o` until the next accept.
- `rdata_o` out 8: read result. Updated at `done_o` of a successful read and held otherwise.
- `scl_oe_o` out 1: 1 = pull SCL low, 0 = release.
- `sda_oe_o` out 1: 1 = pull SDA low, 0 = release.
- `sda_i` in 1: sensed SDA level, already synchronised by the top level.

## Operation
- **Quarter tick:** a counter of width `$clog2(CLK_DIV)` runs only while busy. It produces `qtick` every CLK_DIV cycles, and every bus phase below lasts exactly one quarter.
- **FSM states:** IDLE, START, BIT, STOP, GAP, DONE.
- **IDLE:**
  - `ready_o`=1, both OEs 0.
  - On `start_i`: capture inputs, clear `nack_o`, load byte 0 = DEV_ADDR, go to START.
- **START (2 quarters):** q0 SDA low with SCL released; q1 hold.
- **BIT (4 quarters per bit, 9 bits per byte):**
  - q0: SCL low.
  - q1: drive SDA = ~bit (MSB first). For bit 9, release SDA.
  - q2: release SCL.
  - q3: hold. In the last cycle of q3, sample `sda_i` into a shift register (bits 1-8) or the ack flag (bit 9).
- **Byte sequence, write:** ID, address byte(s), `wdata_i`, then STOP.
- **Byte sequence, read phase 1:** ID, address byte(s), STOP, then GAP.
- **Byte sequence, read phase 2:** START, `DEV_ADDR|1`, one byte received with SDA released for all 9 bits (master NACK), then STOP.
- **ACK check:** after a master-sent byte with ACK_CHECK=1 and sampled ack=1, go to STOP. Skip all remaining bytes and phases, and set `nack_o`=1. A received byte never triggers this.
- **STOP (4 quarters):** q0 SCL low; q1 SDA low; q2 release SCL; q3 release SDA.
- **GAP (4 quarters):** bus idle between read phases, both OEs 0.
- **DONE (1 cycle):** `done_o`=1 and `ready_o`=1. `rdata_o` is updated if the transaction was a successful read. Then go to IDLE.
- **Requests while busy:** `start_i` is ignored and is not queued. `start_i` held high re-triggers in the cycle after DONE.
- **Reset:** takes effect at any time, mid-transaction included. On the next edge both OEs are 0, the FSM is in IDLE and all counters are cleared; no STOP is generated.
- **Reset values:** `ready_o`=1, `done_o`=0, `nack_o`=0, `rdata_o`=8'h00, `scl_oe_o`=0, `sda_oe_o`=0.

## Timing
- Let A = REG_ADDR_BYTES and Q = CLK_DIV. Accept happens in cycle 0. `ready_o`=0 from cycle 1; OEs change only on quarter boundaries starting at cycle 1.
- Write: `done_o` at cycle (2 + 36·(A+2) + 4)·Q + 1. For A=1, that is 114·Q + 1.
- Read: `done_o` at cycle (2 + 36·(A+1) + 4 + 4 + 2 + 72 + 4)·Q + 1. For A=1, that is 160·Q + 1.
- NACK on byte k (1-based): `done_o` at (2 + 36·k + 4)·Q + 1.
- `ready_o` returns to 1 in the `done_o` cycle.
- SDA changes only while SCL is held low, except for the START and STOP edges.

## Test plan
- **Write:** CLK_DIV=4, A=1, slave ACKs, write reg 0x12 = 0x80. The bus must decode as S, 0x42, A, 0x12, A, 0x80, A, P. `done_o` at cycle 457 and `nack_o`=0.
- **NACK:** slave NACKs the ID byte. STOP follows immediately, `done_o` at cycle 169 with `nack_o`=1. With ACK_CHECK=0, the full 114-quarter sequence runs and `nack_o`=0.
- **Read:** reg 0x0A, slave returns 0xA5. The bus must decode as S, 0x42, 0x0A, P, gap, S, 0x43, 0xA5, master NACK, P. `rdata_o`=0xA5 at `done_o`, at cycle 641.
- **Two-byte address:** REG_ADDR_BYTES=2, write 0x3008 = 0x82. Bytes are 0x42, 0x30, 0x08, 0x82, and `done_o` at cycle (2+144+4)·4 + 1 = 601.
- **Reset mid-transaction:** assert `reset` mid-byte 2. Next cycle both OEs are 0 and `ready_o`=1. A new write afterwards completes normally.
- **Busy and held start:**
  - Pulse `start_i` mid-transaction: it is ignored and the timing is unchanged.
  - Hold `start_i` high: a second transaction is accepted in the cycle after `done_o`.
